// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and widths for the two-requester arbiter around the shared FP adder.
// The optional FP_ADD_ARB_STATS_EN build adds per-requester grant counters to fp_add_arbiter.
package fp_add_arbiter_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Operand pair latched at grant time, tagged with its owner.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            id;
  } op_t;

endpackage

// File: rtl/FloatingPointAdder.sv
// Combinational IEEE-754 single adder: align, add/subtract magnitudes, normalise, truncate.
// Subnormal results flush to zero; Out is forced to zero while enable is low.
module FloatingPointAdder
  import fp_add_arbiter_pkg::*;
(
  input  logic [FP_W-1:0] A,
  input  logic [FP_W-1:0] B,
  input  logic            enable,
  output logic [FP_W-1:0] Out
);

  logic [FP_W-1:0] big_op;
  logic [FP_W-1:0] small_op;
  logic [7:0]      e_big;
  logic [7:0]      e_small;
  logic [7:0]      e_diff;
  logic [7:0]      e_res;
  logic [23:0]     m_big;
  logic [23:0]     m_small;
  logic [23:0]     m_shift;
  logic [24:0]     m_sum;
  logic [23:0]     m_norm;
  logic [4:0]      lz;
  logic [FP_W-1:0] result;

  always_comb begin
    big_op   = A;
    small_op = B;
    if (A[30:0] < B[30:0]) begin
      big_op   = B;
      small_op = A;
    end
    // Subnormals use exponent 1 with no hidden bit
    e_big   = (big_op[30:23] == 8'd0) ? 8'd1 : big_op[30:23];
    e_small = (small_op[30:23] == 8'd0) ? 8'd1 : small_op[30:23];
    m_big   = {|big_op[30:23], big_op[22:0]};
    m_small = {|small_op[30:23], small_op[22:0]};
    e_diff  = e_big - e_small;
    m_shift = (e_diff > 8'd24) ? 24'd0 : (m_small >> e_diff);
    if (big_op[31] == small_op[31]) begin
      m_sum = {1'b0, m_big} + {1'b0, m_shift};
    end else begin
      m_sum = {1'b0, m_big} - {1'b0, m_shift};
    end
    lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m_sum[i]) lz = 5'(23 - i);
    end
    m_norm = m_sum[23:0] << lz;
    e_res  = e_big - 8'(lz);
    result = {big_op[31], e_res, m_norm[22:0]};
    if (m_sum[24]) begin
      result = {big_op[31], e_big + 8'd1, m_sum[23:1]};
    end else if ((m_sum == 25'd0) || ({1'b0, e_big} <= {4'd0, lz})) begin
      result = '0;
    end
  end

  assign Out = enable ? result : '0;

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FloatingPointAdder between two requesters (IDLE/ISSUE/RESP).
// Define FP_ADD_ARB_STATS_EN to build the grant_cnt0/grant_cnt1 counters and ports.
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FP_W-1:0]  req0_a,
  input  logic [FP_W-1:0]  req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FP_W-1:0]  req1_a,
  input  logic [FP_W-1:0]  req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
`ifdef FP_ADD_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  output logic [FP_W-1:0]  rsp_sum
);

  state_t          state;
  state_t          state_nxt;
  op_t             op_q;
  op_t             op_sel;
  logic            last_grant;
  logic            accept;
  logic            adder_en;
  logic [FP_W-1:0] adder_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant decision is combinational so the transfer completes in the IDLE cycle.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    adder_en   = 1'b0;
    op_sel     = '{a: req0_a, b: req0_b, id: 1'b0};
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (req0_valid && (!req1_valid || last_grant)) begin
            req0_ready = 1'b1;
            accept     = 1'b1;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            accept     = 1'b1;
            op_sel     = '{a: req1_a, b: req1_b, id: 1'b1};
          end
          if (accept) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        adder_en  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      last_grant <= 1'b1;
      rsp_sum    <= '0;
      rsp_id     <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op_sel;
        last_grant <= op_sel.id;
      end
      if (state == ISSUE) begin
        rsp_sum <= adder_out;
        rsp_id  <= op_q.id;
      end
    end
  end

  assign rsp_valid = (state == RESP);

  FloatingPointAdder u_adder (
    .A      (op_q.a),
    .B      (op_q.b),
    .enable (adder_en),
    .Out    (adder_out)
  );

`ifdef FP_ADD_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (req1_valid && req1_ready) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: exact-sum vector table with a response scoreboard.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_sum;
`ifdef FP_ADD_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  typedef struct {
    logic        id;
    logic [31:0] sum;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Operand pairs whose IEEE sums are exact, so truncation never matters.
  logic [31:0] va [7] = '{32'h3F800000, 32'h41360000, 32'h40400000, 32'h3F000000,
                          32'h41200000, 32'h40000000, 32'h42C80000};
  logic [31:0] vb [7] = '{32'h3F800000, 32'h40D00000, 32'h40A00000, 32'h3E800000,
                          32'hC0800000, 32'hC0400000, 32'h3F800000};
  logic [31:0] vs [7] = '{32'h40000000, 32'h418F0000, 32'h41000000, 32'h3F400000,
                          32'h40C00000, 32'hBF800000, 32'h42CA0000};

  always #5 clk = ~clk;

  fp_add_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
`ifdef FP_ADD_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .rsp_sum    (rsp_sum)
  );

  task automatic test_reset;
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
`ifdef FP_ADD_ARB_STATS_EN
    checks++; if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", grant_cnt0, grant_cnt1);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single(input logic id, input int k);
    exp_t e;
    int   n;
    logic got;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = va[k]; req1_b = vb[k]; end
    else    begin req0_valid = 1'b1; req0_a = va[k]; req0_b = vb[k]; end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      got = id ? req1_ready : req0_ready;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL single%0d_accept: ready=0 want 1 within %0d cycles", k, n);
    end else begin
      sb.push_back('{id: id, sum: vs[k]});
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single%0d_lat1: rsp_valid=%b want 0", k, rsp_valid); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL single%0d_issue_ready: got %b%b want 00", k, req0_ready, req1_ready);
      end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single%0d_lat2: rsp_valid=%b want 1", k, rsp_valid); end
      e = sb.pop_front();
      checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL single%0d_id: got %b want %b", k, rsp_id, e.id); end
      checks++; if (rsp_sum !== e.sum) begin errors++; $display("FAIL single%0d_sum: got %h want %h", k, rsp_sum, e.sum); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness;
    int   idx0 = 0, idx1 = 0, nacc = 0, nrsp = 0, cyc = 0;
    logic order [4] = '{1'bx, 1'bx, 1'bx, 1'bx};
    logic acc0, acc1;
    exp_t e;
    @(posedge clk); #1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = va[2]; req0_b = vb[2];
    req1_valid = 1'b1; req1_a = va[5]; req1_b = vb[5];
    while (nrsp < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0 && acc1) begin checks++; errors++; $display("FAIL fair_both_ready: got 11 want one-hot"); end
      if (acc0) begin
        if (nacc < 4) order[nacc] = 1'b0;
        nacc++; sb.push_back('{id: 1'b0, sum: vs[2 + idx0]});
      end
      if (acc1) begin
        if (nacc < 4) order[nacc] = 1'b1;
        nacc++; sb.push_back('{id: 1'b1, sum: vs[5 + idx1]});
      end
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL fair_extra_rsp: id=%b sum=%h with nothing pending", rsp_id, rsp_sum);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_sum !== e.sum) begin
            errors++; $display("FAIL fair_rsp%0d: got id=%b sum=%h want id=%b sum=%h", nrsp, rsp_id, rsp_sum, e.id, e.sum);
          end
        end
      end
      @(posedge clk); #1;
      if (acc0) begin
        idx0++;
        if (idx0 < 2) begin req0_a = va[2 + idx0]; req0_b = vb[2 + idx0]; end
        else req0_valid = 1'b0;
      end
      if (acc1) begin
        idx1++;
        if (idx1 < 2) begin req1_a = va[5 + idx1]; req1_b = vb[5 + idx1]; end
        else req1_valid = 1'b0;
      end
    end
    checks++; if (nrsp != 4) begin errors++; $display("FAIL fair_rsp_count: got %0d want 4", nrsp); end
    checks++; if (nacc != 4) begin errors++; $display("FAIL fair_accept_count: got %0d want 4", nacc); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] !== 1'(k % 2)) begin errors++; $display("FAIL fair_grant%0d: got %b want %0d", k, order[k], k % 2); end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fair_leftover: got %0d pending want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   n;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = va[6]; req0_b = vb[6];
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    checks++;
    if (!req0_ready) begin errors++; $display("FAIL bp_accept: ready=0 want 1"); end
    sb.push_back('{id: 1'b0, sum: vs[6]});
    @(posedge clk); #1;
    // New requests arrive while the first is in flight
    req0_a = va[3]; req0_b = vb[3];
    req1_valid = 1'b1; req1_a = va[4]; req1_b = vb[4];
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", i, rsp_valid); end
      checks++; if (rsp_sum !== e.sum) begin errors++; $display("FAIL bp_sum%0d: got %h want %h", i, rsp_sum, e.sum); end
      checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL bp_id%0d: got %b want %b", i, rsp_id, e.id); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready%0d: got %b%b want 00", i, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: rsp_valid=%b want 0", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight;
    exp_t e;
    int   n;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = va[3]; req1_b = vb[3];
    n = 0;
    do begin @(negedge clk); n++; end while (!req1_ready && n < 20);
    checks++; if (!req1_ready) begin errors++; $display("FAIL rstmid_accept: ready=0 want 1"); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_norsp%0d: got %b want 0", i, rsp_valid); end
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = va[0]; req0_b = vb[0];
    req1_valid = 1'b1; req1_a = va[1]; req1_b = vb[1];
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_tie: got ready %b%b want 10", req0_ready, req1_ready);
    end
    sb.push_back('{id: 1'b0, sum: vs[0]});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum) begin
      errors++; $display("FAIL rstmid_rsp: got v=%b id=%b sum=%h want v=1 id=%b sum=%h", rsp_valid, rsp_id, rsp_sum, e.id, e.sum);
    end
    @(posedge clk); #1;
  endtask

`ifdef FP_ADD_ARB_STATS_EN
  task automatic test_stats;
    int   n = 0, cyc = 0;
    logic acc;
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = va[0]; req0_b = vb[0];
    while (n < 65537 && cyc < 300000) begin
      @(negedge clk); cyc++;
      acc = req0_valid && req0_ready;
      if (acc) n++;
      @(posedge clk); #1;
      if (n == 65537) req0_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (grant_cnt0 !== 16'h0001) begin errors++; $display("FAIL stats_cnt0: got %h want 0001", grant_cnt0); end
    checks++; if (grant_cnt1 !== 16'h0000) begin errors++; $display("FAIL stats_cnt1: got %h want 0000", grant_cnt1); end
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single(1'b0, 0);
    test_single(1'b1, 1);
    test_single(1'b0, 4);
    test_single(1'b1, 5);
    test_fairness();
    test_backpressure();
    test_reset_midflight();
`ifdef FP_ADD_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
